// File: rtl/snake_body_ring.sv
// snake_body_ring: snake body kept in a circular buffer, drawn incrementally.
// Build option SNAKE_WRAP_EN: grid edges wrap instead of killing the snake.
module snake_body_ring #(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int COORD_W   = 6,
  parameter int MAX_LEN   = 64,
  parameter int INIT_LEN  = 3,
  parameter int CELL_LOG2 = 2,
  parameter int START_X   = 10,
  parameter int START_Y   = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step,
  input  logic [1:0]                   dir,
  input  logic                         grow,
  input  logic                         restart,
  input  logic                         draw_ready,
  output logic                         draw_valid,
  output logic [COORD_W+CELL_LOG2-1:0] draw_x,
  output logic [COORD_W+CELL_LOG2-1:0] draw_y,
  output logic [2:0]                   draw_colour,
  output logic                         busy,
  output logic                         dead,
  output logic [$clog2(MAX_LEN):0]     length
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int OW = 2 * CELL_LOG2;

  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] X0   = COORD_W'(START_X - INIT_LEN + 1);
  localparam logic [COORD_W-1:0] Y0   = COORD_W'(START_Y);
  localparam logic [PW-1:0]      P1   = PW'(1);
  localparam logic [PW:0]        L1   = (PW+1)'(1);
  localparam logic [PW:0]        LMAX = (PW+1)'(MAX_LEN);
  localparam logic [PW:0]        ILST = (PW+1)'(INIT_LEN - 1);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_INIT_WR,
    S_INIT_DRAW,
    S_IDLE,
    S_CALC,
    S_SCAN,
    S_COMMIT,
    S_DRAW_HEAD,
    S_DRAW_TAIL,
    S_DEAD
  } state_t;

  state_t state, state_nx;

  logic [COORD_W-1:0] mem_x [MAX_LEN];
  logic [COORD_W-1:0] mem_y [MAX_LEN];

  logic [PW-1:0]      head, tail, sp;
  logic [PW:0]        cnt;
  logic [OW-1:0]      off;
  logic [1:0]         last_dir, cur_dir;
  logic               grow_q, grow_eff;
  logic [COORD_W-1:0] hx, hy, nx, ny;
  logic [COORD_W-1:0] nx_q, ny_q, dcx, dcy, tx, ty;
  logic [COORD_W-1:0] cell_x, cell_y;
  logic               hit_wall, hit_body, xfer, off_last;
  logic               wr_en;
  logic [PW-1:0]      wr_addr;
  logic [COORD_W-1:0] wr_x, wr_y;

  assign hx       = mem_x[head];
  assign hy       = mem_y[head];
  assign hit_body = (mem_x[sp] == nx_q) && (mem_y[sp] == ny_q);
  assign grow_eff = grow && (length != LMAX);
  assign off_last = &off;
  assign xfer     = draw_valid && draw_ready;

  always_comb begin
    nx       = hx;
    ny       = hy;
    hit_wall = 1'b0;
    unique case (cur_dir)
      2'd0: begin
        nx = hx + ONE;
        if (hx == XMAX) begin
          hit_wall = !WRAP;
          nx       = '0;
        end
      end
      2'd1: begin
        nx = hx - ONE;
        if (hx == '0) begin
          hit_wall = !WRAP;
          nx       = XMAX;
        end
      end
      2'd2: begin
        ny = hy - ONE;
        if (hy == '0) begin
          hit_wall = !WRAP;
          ny       = YMAX;
        end
      end
      2'd3: begin
        ny = hy + ONE;
        if (hy == YMAX) begin
          hit_wall = !WRAP;
          ny       = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT_WR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT_WR:
        if (cnt == ILST) state_nx = S_INIT_DRAW;
      S_INIT_DRAW:
        if (xfer && off_last && sp == head) state_nx = S_IDLE;
      S_IDLE:
        if (step) state_nx = S_CALC;
      S_CALC:
        if (hit_wall)                    state_nx = S_DEAD;
        else if (!grow_q && length == L1) state_nx = S_COMMIT;
        else                             state_nx = S_SCAN;
      S_SCAN:
        if (hit_body)        state_nx = S_DEAD;
        else if (sp == head) state_nx = S_COMMIT;
      S_COMMIT:
        state_nx = S_DRAW_HEAD;
      S_DRAW_HEAD:
        if (xfer && off_last) state_nx = grow_q ? S_IDLE : S_DRAW_TAIL;
      S_DRAW_TAIL:
        if (xfer && off_last) state_nx = S_IDLE;
      S_DEAD:
        if (restart) state_nx = S_INIT_WR;
      default:
        state_nx = S_INIT_WR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      sp       <= '0;
      cnt      <= '0;
      off      <= '0;
      length   <= '0;
      last_dir <= 2'd0;
      cur_dir  <= 2'd0;
      grow_q   <= 1'b0;
      nx_q     <= '0;
      ny_q     <= '0;
      dcx      <= '0;
      dcy      <= '0;
      tx       <= '0;
      ty       <= '0;
    end else begin
      case (state)
        S_INIT_WR: begin
          cnt    <= cnt + L1;
          head   <= cnt[PW-1:0];
          length <= cnt + L1;
        end
        S_INIT_DRAW:
          if (xfer) begin
            off <= off + 1'b1;
            if (off_last) sp <= sp + P1;
          end
        S_IDLE:
          if (step) begin
            cur_dir <= (dir == (last_dir ^ 2'd1)) ? last_dir : dir;
            grow_q  <= grow_eff;
            sp      <= grow_eff ? tail : tail + P1;
          end
        S_CALC: begin
          nx_q <= nx;
          ny_q <= ny;
        end
        S_SCAN:
          sp <= sp + P1;
        S_COMMIT: begin
          head     <= head + P1;
          last_dir <= cur_dir;
          if (grow_q) length <= length + L1;
          dcx <= nx_q;
          dcy <= ny_q;
          // tail slot may be overwritten by this commit when the ring is full
          tx  <= mem_x[tail];
          ty  <= mem_y[tail];
        end
        S_DRAW_HEAD:
          if (xfer) begin
            off <= off + 1'b1;
            if (off_last) begin
              dcx <= tx;
              dcy <= ty;
            end
          end
        S_DRAW_TAIL:
          if (xfer) begin
            off <= off + 1'b1;
            if (off_last) tail <= tail + P1;
          end
        S_DEAD:
          if (restart) begin
            head     <= '0;
            tail     <= '0;
            sp       <= '0;
            cnt      <= '0;
            off      <= '0;
            length   <= '0;
            last_dir <= 2'd0;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_en   = (state == S_INIT_WR) || (state == S_COMMIT);
    wr_addr = head + P1;
    wr_x    = nx_q;
    wr_y    = ny_q;
    if (state == S_INIT_WR) begin
      wr_addr = cnt[PW-1:0];
      wr_x    = X0 + COORD_W'(cnt);
      wr_y    = Y0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_x[wr_addr] <= wr_x;
      mem_y[wr_addr] <= wr_y;
    end
  end

  assign cell_x = (state == S_INIT_DRAW) ? mem_x[sp] : dcx;
  assign cell_y = (state == S_INIT_DRAW) ? mem_y[sp] : dcy;

  assign draw_valid  = (state == S_INIT_DRAW) || (state == S_DRAW_HEAD) ||
                       (state == S_DRAW_TAIL);
  assign draw_x      = {cell_x, off[CELL_LOG2-1:0]};
  assign draw_y      = {cell_y, off[OW-1:CELL_LOG2]};
  assign draw_colour = ((state == S_INIT_DRAW) || (state == S_DRAW_HEAD)) ?
                       3'b100 : 3'b000;
  assign busy        = (state != S_IDLE);
  assign dead        = (state == S_DEAD);

endmodule

// File: tb/tb_snake_body_ring.sv
// tb_snake_body_ring: directed moves checked against a small snake model.
// Covers init, moves, reversal, growth saturation, backpressure, deaths.
module tb_snake_body_ring;

  localparam int ML = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step = 1'b0;
  logic [1:0] dir = 2'd0;
  logic       grow = 1'b0;
  logic       restart = 1'b0;
  logic       draw_ready;
  logic       draw_valid;
  logic [7:0] draw_x, draw_y;
  logic [2:0] draw_colour;
  logic       busy, dead;
  logic [3:0] length;

  int checks = 0;
  int errors = 0;

  logic [18:0] px_q[$];
  logic [15:0] body[$];
  logic [1:0]  ld;
  bit          rnd_ready = 1'b0;
  bit          stalled = 1'b0;
  logic [18:0] stall_px;

  snake_body_ring #(.MAX_LEN(ML)) dut (
    .clk(clk),
    .rst(rst),
    .step(step),
    .dir(dir),
    .grow(grow),
    .restart(restart),
    .draw_ready(draw_ready),
    .draw_valid(draw_valid),
    .draw_x(draw_x),
    .draw_y(draw_y),
    .draw_colour(draw_colour),
    .busy(busy),
    .dead(dead),
    .length(length)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    draw_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      draw_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (stalled)
      check("stall_hold", {13'd0, draw_valid, draw_x, draw_y, draw_colour},
            {13'd0, 1'b1, stall_px});
    stalled  = draw_valid && !draw_ready;
    stall_px = {draw_x, draw_y, draw_colour};
    if (draw_valid && draw_ready)
      px_q.push_back({draw_x, draw_y, draw_colour});
  end

  task automatic check_cell(input string tag, input logic [15:0] c,
                            input logic [2:0] col);
    for (int oy = 0; oy < 4; oy++)
      for (int ox = 0; ox < 4; ox++) begin
        int ex, ey;
        logic [18:0] e, g;
        ex = int'(c[15:8]) * 4 + ox;
        ey = int'(c[7:0]) * 4 + oy;
        e  = {ex[7:0], ey[7:0], col};
        g  = (px_q.size() > 0) ? px_q.pop_front() : '1;
        check(tag, {13'd0, g}, {13'd0, e});
      end
  endtask

  task automatic model_reset();
    body.delete();
    body.push_back(16'h080a);
    body.push_back(16'h090a);
    body.push_back(16'h0a0a);
    ld = 2'd0;
  endtask

  task automatic model_step(input logic [1:0] d_in, input bit g,
                            output bit die, output bit geff,
                            output logic [15:0] nh, output logic [15:0] ot);
    logic [1:0] d;
    int hx, hy, nxv, nyv;
    d   = (d_in == (ld ^ 2'd1)) ? ld : d_in;
    hx  = int'(body[body.size()-1][15:8]);
    hy  = int'(body[body.size()-1][7:0]);
    nxv = hx;
    nyv = hy;
    die = 1'b0;
    case (d)
      2'd0: nxv = hx + 1;
      2'd1: nxv = hx - 1;
      2'd2: nyv = hy - 1;
      default: nyv = hy + 1;
    endcase
    if (nxv < 0 || nxv >= 40 || nyv < 0 || nyv >= 30) begin
`ifdef SNAKE_WRAP_EN
      nxv = (nxv + 40) % 40;
      nyv = (nyv + 30) % 30;
`else
      die = 1'b1;
`endif
    end
    geff = g && (body.size() < ML);
    nh   = {nxv[7:0], nyv[7:0]};
    ot   = body[0];
    if (!die)
      for (int i = (geff ? 0 : 1); i < body.size(); i++)
        if (body[i] == nh) die = 1'b1;
    if (!die) begin
      body.push_back(nh);
      if (!geff) void'(body.pop_front());
      ld = d;
    end
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_npx"}, px_q.size(), 32'd48);
    for (int i = 0; i < 3; i++) check_cell({tag, "_cell"}, body[i], 3'b100);
    check({tag, "_len"}, {28'd0, length}, 32'd3);
    check({tag, "_dead"}, {31'd0, dead}, 32'd0);
  endtask

  task automatic move(input string tag, input logic [1:0] d, input bit g,
                      input bit poke);
    bit die, geff;
    logic [15:0] nh, ot;
    int n, exp_n, l0;
    l0 = body.size();
    model_step(d, g, die, geff, nh, ot);
    px_q.delete();
    step = 1'b1;
    dir  = d;
    grow = g;
    @(posedge clk);
    #1;
    step = 1'b0;
    grow = 1'b0;
    n = 0;
    while (busy && !dead && n < 2000) begin
      n++;
      step = poke && (n == 5);
      @(posedge clk);
      #1;
    end
    step = 1'b0;
    check({tag, "_dead"}, {31'd0, dead}, {31'd0, die});
    if (die) begin
      repeat (40) @(posedge clk);
      #1;
      check({tag, "_nodraw"}, px_q.size(), 32'd0);
      check({tag, "_dead_hold"}, {31'd0, dead}, 32'd1);
    end else begin
      exp_n = geff ? 16 : 32;
      check({tag, "_npx"}, px_q.size(), exp_n);
      check_cell({tag, "_head"}, nh, 3'b100);
      if (!geff) check_cell({tag, "_tail"}, ot, 3'b000);
      check({tag, "_len"}, {28'd0, length}, body.size());
      if (!rnd_ready)
        check({tag, "_cycles"}, n, 2 + (geff ? l0 : l0 - 1) + exp_n);
      if (poke) begin
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_noqueue"}, {31'd0, busy}, 32'd0);
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_valid", {31'd0, draw_valid}, 32'd0);
    check("rst_len", {28'd0, length}, 32'd0);
    check("rst_dead", {31'd0, dead}, 32'd0);
    check("rst_pix", {13'd0, draw_x, draw_y, draw_colour}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    px_q.delete();
    wait_init("init");

    move("plain", 2'd0, 1'b0, 1'b0);
    move("poke", 2'd0, 1'b0, 1'b1);
    move("rev", 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) move("grow", 2'd0, 1'b1, 1'b0);
    move("grow_sat", 2'd0, 1'b1, 1'b0);
    check("sat_len", {28'd0, length}, 32'd8);

    rnd_ready = 1'b1;
    for (int i = 0; i < 3; i++) move("bp", 2'd0, 1'b0, 1'b0);
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    move("sc_py", 2'd3, 1'b0, 1'b0);
    move("sc_mx", 2'd1, 1'b0, 1'b0);
    move("sc_my", 2'd2, 1'b0, 1'b0);
    check("sc_dead", {31'd0, dead}, 32'd1);

    model_reset();
    px_q.delete();
    restart = 1'b1;
    step    = 1'b1;
    dir     = 2'd0;
    @(posedge clk);
    #1;
    restart = 1'b0;
    step    = 1'b0;
    wait_init("restart");

    for (int i = 0; i < 29; i++) move("wall_run", 2'd0, 1'b0, 1'b0);
    check("wall_headx", {24'd0, body[body.size()-1][15:8]}, 32'd39);
    move("wall", 2'd0, 1'b0, 1'b0);

    rst = 1'b1;
    #1;
    check("rst2_busy", {31'd0, busy}, 32'd1);
    check("rst2_len", {28'd0, length}, 32'd0);
    check("rst2_dead", {31'd0, dead}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
